mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Memory-stage load/store unit sitting directly downstream of the EX/MEM pipeline register, consuming its `_m` control and data outputs. Converts loads and stores into a single-outstanding request/ready transaction on the data-memory port. Generates byte strobes and lane-replicated store data, and sign- or zero-extends load data. Stalls the pipeline while a transaction is in flight and flags misaligned accesses instead of issuing them.

## Interface
- `ADDRESS_WIDTH`, default 32: width of `alu_result_m` and `dmem_addr`.
- `DATA_WIDTH`, default 32: data width. Fixed at 32; four byte lanes.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `mem_write_m` in 1: store instruction in MEM.
- `result_src_m` in 2: `2'b01` marks a load.
- `funct3_m` in 3: access size and sign.
- `alu_result_m` in ADDRESS_WIDTH: effective byte address.
- `write_data_m` in DATA_WIDTH: store data, right-justified.
- `dmem_req` out 1: request valid.
- `dmem_we` out 1: request is a write.
- `dmem_addr` out ADDRESS_WIDTH: word address, bits [1:0] = 0.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_wstrb` out 4: byte write enables; 0 for reads.
- `dmem_ready` in 1: memory accepts/completes the request this cycle.
- `dmem_rdata` in 32: read word, valid when `dmem_ready`.
- `read_data_m` out 32: extended load result for the MEM/WB register.
- `stall_m` out 1: hold IF/ID/EX and EX/MEM (`en`=0), bubble MEM/WB.
- `misalign_m` out 1: misaligned access detected this cycle.

## Operation
- `mem_op` = `mem_write_m` | (`result_src_m` == 2'b01). Both asserted → store.
- Misalignment:
  - `funct3` 001/101 (halfword) with addr[0] = 1.
  - `funct3` 010 (word) with addr[1:0] ≠ 0.
  - All other `funct3` codes are treated as word for loads and stores, including the alignment check.
- FSM states IDLE, REQ, RESP:
  - IDLE: if `mem_op` and aligned → capture addr[1:0], `funct3`, `we`, `wdata`, `wstrb`; go to REQ. If `mem_op` and misaligned → `misalign_m` = 1 for that cycle, no request, store suppressed, `read_data_m` unchanged, stay in IDLE.
  - REQ: `dmem_req` = 1 with captured, stable fields until `dmem_ready`. On `dmem_ready`, latch the extended load data (loads only) and go to RESP.
  - RESP: one cycle, no request, then IDLE unconditionally. This prevents re-issue of the still-resident instruction.
- `stall_m` = (IDLE & `mem_op` & aligned) | REQ. It is 0 in RESP, so the instruction advances at the end of RESP.
- Store lanes:
  - sb: `wstrb` = 4'b0001 << addr[1:0]; `wdata` = byte replicated ×4.
  - sh: `wstrb` = 4'b0011 << {addr[1], 1'b0}; `wdata` = halfword replicated ×2.
  - sw: `wstrb` = 4'b1111; `wdata` = word.
- Load extract from `dmem_rdata` using the captured offset:
  - lb/lh: sign-extend. lbu/lhu: zero-extend. lw: pass through.
- `read_data_m` is registered, updated only on load completion, and held otherwise.

## Timing
- Reset values:
  - FSM = IDLE.
  - `dmem_req`, `dmem_we`, `misalign_m` = 0.
  - `dmem_addr`, `dmem_wdata`, `read_data_m` = 0; `dmem_wstrb` = 0.
  - `stall_m` follows its combinational equation from IDLE.
- Reset mid-transaction: `dmem_req` drops immediately (asynchronous). The pending access is abandoned and any late `dmem_ready` is ignored.
- Latency: detect cycle (IDLE) + N REQ cycles (N ≥ 1, ending on the `dmem_ready` cycle) + 1 RESP cycle.
  - Zero-wait memory: op occupies MEM for 3 cycles; `stall_m` high for 2.
- `read_data_m` is valid in RESP (the cycle after `dmem_ready`) and is captured by MEM/WB at the end of RESP.
- Back-to-back memory ops: the second op's detect cycle is the cycle after RESP. No overlap; one outstanding request.
- `dmem_ready` outside REQ: ignored.
- Non-memory instructions: no stall, no request, single-cycle pass-through.

## Test plan
- Reset during REQ with `dmem_req` = 1 → `dmem_req` = 0 within the same cycle, FSM = IDLE, `read_data_m` = 0; a subsequent `dmem_ready` pulse causes no update.
- lw at 0x100, zero-wait, `dmem_rdata` = 0xDEADBEEF → `dmem_req` in cycle 2, `stall_m` = 1,1,0, `read_data_m` = 0xDEADBEEF in RESP.
- lb at 0x103 with rdata 0x80FFFFFF → 0xFFFFFF80; lbu at the same address → 0x00000080; lhu at 0x102 with rdata 0x8001xxxx → 0x00008001.
- sh at 0x202, `write_data_m` = 0x1234ABCD, `dmem_ready` delayed 3 cycles → `dmem_addr` = 0x200, `wstrb` = 4'b1100, `wdata` = 0xABCDABCD held stable; `stall_m` high for 4 cycles.
- sw at 0x301 → `misalign_m` = 1 for one cycle, `dmem_req` never asserted, `stall_m` = 0.
- Two consecutive loads → exactly two `dmem_req` episodes, and each result appears only in its own RESP cycle.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// Data-memory port between the MEM-stage LSU and the data memory.
// Single outstanding request/ready handshake with byte strobes.
interface mem_stage_lsu_if #(
    parameter int ADDRESS_WIDTH = 32
);
    logic                     dmem_req;
    logic                     dmem_we;
    logic [ADDRESS_WIDTH-1:0] dmem_addr;
    logic [31:0]              dmem_wdata;
    logic [3:0]               dmem_wstrb;
    logic                     dmem_ready;
    logic [31:0]              dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_wstrb,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_wstrb,
        output dmem_ready,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: turns the EX/MEM load/store into a single
// outstanding request on the data-memory port, builds byte strobes and
// lane-replicated store data, extends load data, stalls the pipeline while
// the access is in flight and flags misaligned accesses instead of issuing.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no access in flight; detect a new load/store in MEM
// REQ     | request presented with captured fields until dmem_ready
// RESP    | load result valid; instruction leaves MEM at end of cycle
module mem_stage_lsu #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_write_m,
    input  logic [1:0]               result_src_m,
    input  logic [2:0]               funct3_m,
    input  logic [ADDRESS_WIDTH-1:0] alu_result_m,
    input  logic [DATA_WIDTH-1:0]    write_data_m,
    mem_stage_lsu_if.master          dmem,
    output logic [DATA_WIDTH-1:0]    read_data_m,
    output logic                     stall_m,
    output logic                     misalign_m
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic        mem_op;
    logic        is_byte;
    logic        is_half;
    logic        misaligned;
    logic        capture;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;

    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [1:0]               off_q;
    logic [2:0]               funct3_q;
    logic                     we_q;
    logic [31:0]              wdata_q;
    logic [3:0]               wstrb_q;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_word;

    // Decode access size, alignment and store lane placement for the MEM instruction.
    // Unlisted funct3 codes fall through to word size.
    always_comb begin
        mem_op     = mem_write_m | (result_src_m == 2'b01);
        is_byte    = (funct3_m[1:0] == 2'b00);
        is_half    = (funct3_m[1:0] == 2'b01);
        misaligned = is_half ? alu_result_m[0]
                             : (!is_byte && (alu_result_m[1:0] != 2'b00));
        st_wstrb   = 4'b1111;
        st_wdata   = write_data_m[31:0];
        if (is_byte) begin
            st_wstrb = 4'b0001 << alu_result_m[1:0];
            st_wdata = {4{write_data_m[7:0]}};
        end else if (is_half) begin
            st_wstrb = 4'b0011 << {alu_result_m[1], 1'b0};
            st_wdata = {2{write_data_m[15:0]}};
        end
    end

    // FSM next state, stall and misalign flags.
    always_comb begin
        state_d    = state_q;
        stall_m    = 1'b0;
        misalign_m = 1'b0;
        capture    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    if (misaligned) begin
                        misalign_m = 1'b1;
                    end else begin
                        stall_m = 1'b1;
                        capture = 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stall_m = 1'b1;
                if (dmem.dmem_ready) state_d = ST_RESP;
            end
            // The instruction is still resident here; going straight back to
            // IDLE without looking at mem_op is what prevents a re-issue.
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Extract and extend the addressed lane of the returned word.
    always_comb begin
        ld_byte = dmem.dmem_rdata[{off_q, 3'b000} +: 8];
        ld_half = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (funct3_q[1:0])
            2'b00:   ld_word = funct3_q[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_word = funct3_q[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_word = dmem.dmem_rdata;
        endcase
    end

    // Capture request fields on detect; latch load result on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            off_q       <= '0;
            funct3_q    <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            read_data_m <= '0;
        end else begin
            if (capture) begin
                addr_q   <= {alu_result_m[ADDRESS_WIDTH-1:2], 2'b00};
                off_q    <= alu_result_m[1:0];
                funct3_q <= funct3_m;
                we_q     <= mem_write_m;
                wdata_q  <= mem_write_m ? st_wdata : 32'h0;
                wstrb_q  <= mem_write_m ? st_wstrb : 4'h0;
            end
            if ((state_q == ST_REQ) && dmem.dmem_ready && !we_q) begin
                read_data_m <= ld_word;
            end
        end
    end

    assign dmem.dmem_req   = (state_q == ST_REQ);
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with hand-computed expectations.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_write_m;
    logic [1:0]  result_src_m;
    logic [2:0]  funct3_m;
    logic [31:0] alu_result_m;
    logic [31:0] write_data_m;
    logic [31:0] read_data_m;
    logic        stall_m;
    logic        misalign_m;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_rd;

    mem_stage_lsu_if #(.ADDRESS_WIDTH(32)) dmem_bus ();

    mem_stage_lsu #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_write_m  (mem_write_m),
        .result_src_m (result_src_m),
        .funct3_m     (funct3_m),
        .alu_result_m (alu_result_m),
        .write_data_m (write_data_m),
        .dmem         (dmem_bus),
        .read_data_m  (read_data_m),
        .stall_m      (stall_m),
        .misalign_m   (misalign_m)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic we, input logic [1:0] rs, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        mem_write_m  = we;
        result_src_m = rs;
        funct3_m     = f3;
        alu_result_m = a;
        write_data_m = wd;
    endtask

    task automatic nop();
        drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        nop();
        dmem_bus.dmem_ready = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({dmem_bus.dmem_req, dmem_bus.dmem_we, misalign_m, stall_m} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl: req/we/mis/stall=%b expected 0000",
                     {dmem_bus.dmem_req, dmem_bus.dmem_we, misalign_m, stall_m});
        end
        checks++;
        if ({dmem_bus.dmem_addr, dmem_bus.dmem_wdata, dmem_bus.dmem_wstrb, read_data_m} !== 100'h0) begin
            failures++;
            $display("FAIL reset_data: addr=%h wdata=%h wstrb=%b rd=%h expected all 0",
                     dmem_bus.dmem_addr, dmem_bus.dmem_wdata, dmem_bus.dmem_wstrb, read_data_m);
        end
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        last_rd = 32'h0;
    endtask

    task automatic test_nonmem();
        logic [1:0] rs_tab [3] = '{2'b00, 2'b10, 2'b11};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, rs_tab[i], 3'b010, 32'h0000_0101, 32'hFFFF_FFFF);
            dmem_bus.dmem_ready = 1'b1;
            @(negedge clk);
            checks++;
            if ({stall_m, dmem_bus.dmem_req, misalign_m} !== 3'b000) begin
                failures++;
                $display("FAIL nonmem[%0d]: stall/req/mis=%b expected 000", i,
                         {stall_m, dmem_bus.dmem_req, misalign_m});
            end
            next_cycle();
        end
        dmem_bus.dmem_ready = 1'b0;
        nop();
    endtask

    task automatic test_lw_zero_wait();
        logic exp_req   [3] = '{1'b0, 1'b1, 1'b0};
        logic exp_stall [3] = '{1'b1, 1'b1, 1'b0};
        drive(1'b0, 2'b01, 3'b010, 32'h0000_0100, 32'h0);
        dmem_bus.dmem_ready = 1'b1;
        dmem_bus.dmem_rdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({dmem_bus.dmem_req, stall_m} !== {exp_req[c], exp_stall[c]}) begin
                failures++;
                $display("FAIL lw_seq[c%0d]: req/stall=%b expected %b", c + 1,
                         {dmem_bus.dmem_req, stall_m}, {exp_req[c], exp_stall[c]});
            end
            if (c == 1) begin
                checks++;
                if ({dmem_bus.dmem_addr, dmem_bus.dmem_we, dmem_bus.dmem_wstrb} !== {32'h0000_0100, 1'b0, 4'b0000}) begin
                    failures++;
                    $display("FAIL lw_req_fields: addr=%h we=%b wstrb=%b expected 00000100 0 0000",
                             dmem_bus.dmem_addr, dmem_bus.dmem_we, dmem_bus.dmem_wstrb);
                end
            end
            if (c == 2) begin
                checks++;
                if (read_data_m !== 32'hDEAD_BEEF) begin
                    failures++;
                    $display("FAIL lw_data: got %h expected deadbeef", read_data_m);
                end
            end
            next_cycle();
        end
        last_rd = 32'hDEAD_BEEF;
        nop();
        dmem_bus.dmem_ready = 1'b0;
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3_tab [5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000};
        logic [31:0] a_tab  [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101};
        logic [31:0] rd_tab [5] = '{32'h80FF_FFFF, 32'h80FF_FFFF, 32'h8001_1234, 32'h8001_1234, 32'h0000_7F00};
        logic [31:0] ex_tab [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_8001, 32'hFFFF_8001, 32'h0000_007F};
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 2'b01, f3_tab[i], a_tab[i], 32'h0);
            dmem_bus.dmem_ready = 1'b1;
            dmem_bus.dmem_rdata = rd_tab[i];
            next_cycle();
            @(negedge clk);
            checks++;
            if ({dmem_bus.dmem_req, dmem_bus.dmem_addr} !== {1'b1, a_tab[i] & 32'hFFFF_FFFC}) begin
                failures++;
                $display("FAIL ld_req[%0d]: req=%b addr=%h expected 1 %h", i,
                         dmem_bus.dmem_req, dmem_bus.dmem_addr, a_tab[i] & 32'hFFFF_FFFC);
            end
            next_cycle();
            @(negedge clk);
            checks++;
            if (read_data_m !== ex_tab[i]) begin
                failures++;
                $display("FAIL ld_ext[%0d]: got %h expected %h", i, read_data_m, ex_tab[i]);
            end
            next_cycle();
            nop();
        end
        last_rd = ex_tab[4];
        dmem_bus.dmem_ready = 1'b0;
    endtask

    task automatic test_sh_wait();
        int stall_cnt = 0;
        drive(1'b1, 2'b00, 3'b001, 32'h0000_0202, 32'h1234_ABCD);
        dmem_bus.dmem_ready = 1'b0;
        dmem_bus.dmem_rdata = 32'h5555_5555;
        for (int c = 0; c < 5; c++) begin
            dmem_bus.dmem_ready = (c == 3);
            @(negedge clk);
            if (stall_m) stall_cnt++;
            if (c >= 1 && c <= 3) begin
                checks++;
                if ({dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr, dmem_bus.dmem_wstrb, dmem_bus.dmem_wdata}
                    !== {1'b1, 1'b1, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD}) begin
                    failures++;
                    $display("FAIL sh_req[c%0d]: req=%b we=%b addr=%h wstrb=%b wdata=%h expected 1 1 00000200 1100 abcdabcd",
                             c + 1, dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr,
                             dmem_bus.dmem_wstrb, dmem_bus.dmem_wdata);
                end
            end
            next_cycle();
        end
        nop();
        dmem_bus.dmem_ready = 1'b0;
        checks++;
        if (stall_cnt != 4) begin
            failures++;
            $display("FAIL sh_stall_cycles: got %0d expected 4", stall_cnt);
        end
        checks++;
        if (read_data_m !== last_rd) begin
            failures++;
            $display("FAIL sh_rd_held: got %h expected %h", read_data_m, last_rd);
        end
    endtask

    task automatic test_store_lanes();
        logic [2:0]  f3_tab [3] = '{3'b000, 3'b000, 3'b010};
        logic [31:0] a_tab  [3] = '{32'h0000_0011, 32'h0000_0013, 32'h0000_0400};
        logic [31:0] wd_tab [3] = '{32'hCAFE_005A, 32'h0000_00E1, 32'h89AB_CDEF};
        logic [3:0]  st_tab [3] = '{4'b0010, 4'b1000, 4'b1111};
        logic [31:0] wx_tab [3] = '{32'h5A5A_5A5A, 32'hE1E1_E1E1, 32'h89AB_CDEF};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b00, f3_tab[i], a_tab[i], wd_tab[i]);
            dmem_bus.dmem_ready = 1'b1;
            next_cycle();
            @(negedge clk);
            checks++;
            if ({dmem_bus.dmem_req, dmem_bus.dmem_wstrb, dmem_bus.dmem_wdata} !== {1'b1, st_tab[i], wx_tab[i]}) begin
                failures++;
                $display("FAIL st_lanes[%0d]: req=%b wstrb=%b wdata=%h expected 1 %b %h", i,
                         dmem_bus.dmem_req, dmem_bus.dmem_wstrb, dmem_bus.dmem_wdata, st_tab[i], wx_tab[i]);
            end
            next_cycle();
            next_cycle();
            nop();
        end
        dmem_bus.dmem_ready = 1'b0;
    endtask

    task automatic test_misalign();
        logic        we_tab [3] = '{1'b1, 1'b0, 1'b0};
        logic [2:0]  f3_tab [3] = '{3'b010, 3'b001, 3'b010};
        logic [31:0] a_tab  [3] = '{32'h0000_0301, 32'h0000_0101, 32'h0000_0102};
        for (int i = 0; i < 3; i++) begin
            drive(we_tab[i], we_tab[i] ? 2'b00 : 2'b01, f3_tab[i], a_tab[i], 32'h7777_7777);
            dmem_bus.dmem_ready = 1'b1;
            dmem_bus.dmem_rdata = 32'h1357_9BDF;
            @(negedge clk);
            checks++;
            if ({misalign_m, stall_m, dmem_bus.dmem_req} !== 3'b100) begin
                failures++;
                $display("FAIL mis_detect[%0d]: mis/stall/req=%b expected 100", i,
                         {misalign_m, stall_m, dmem_bus.dmem_req});
            end
            next_cycle();
            nop();
            @(negedge clk);
            checks++;
            if ({misalign_m, dmem_bus.dmem_req, read_data_m} !== {2'b00, last_rd}) begin
                failures++;
                $display("FAIL mis_after[%0d]: mis=%b req=%b rd=%h expected 0 0 %h", i,
                         misalign_m, dmem_bus.dmem_req, read_data_m, last_rd);
            end
            next_cycle();
        end
        dmem_bus.dmem_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic        exp_req   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        exp_stall [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] exp_rd    [6];
        logic        prev_req = 1'b0;
        int          episodes = 0;
        exp_rd = '{last_rd, last_rd, 32'hAAAA_0001, 32'hAAAA_0001, 32'hAAAA_0001, 32'hBBBB_0002};
        dmem_bus.dmem_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 0) begin
                drive(1'b0, 2'b01, 3'b010, 32'h0000_0010, 32'h0);
                dmem_bus.dmem_rdata = 32'hAAAA_0001;
            end else if (c == 3) begin
                drive(1'b0, 2'b01, 3'b010, 32'h0000_0014, 32'h0);
                dmem_bus.dmem_rdata = 32'hBBBB_0002;
            end
            @(negedge clk);
            if (dmem_bus.dmem_req && !prev_req) episodes++;
            prev_req = dmem_bus.dmem_req;
            checks++;
            if ({dmem_bus.dmem_req, stall_m, read_data_m} !== {exp_req[c], exp_stall[c], exp_rd[c]}) begin
                failures++;
                $display("FAIL b2b[c%0d]: req=%b stall=%b rd=%h expected %b %b %h", c + 1,
                         dmem_bus.dmem_req, stall_m, read_data_m, exp_req[c], exp_stall[c], exp_rd[c]);
            end
            next_cycle();
        end
        nop();
        @(negedge clk);
        if (dmem_bus.dmem_req && !prev_req) episodes++;
        checks++;
        if (episodes != 2) begin
            failures++;
            $display("FAIL b2b_episodes: got %0d expected 2", episodes);
        end
        next_cycle();
        last_rd = 32'hBBBB_0002;
        dmem_bus.dmem_ready = 1'b0;
    endtask

    task automatic test_reset_mid_txn();
        drive(1'b0, 2'b01, 3'b010, 32'h0000_0040, 32'h0);
        dmem_bus.dmem_ready = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if (dmem_bus.dmem_req !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre: req=%b expected 1", dmem_bus.dmem_req);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({dmem_bus.dmem_req, read_data_m} !== {1'b0, 32'h0}) begin
            failures++;
            $display("FAIL rstmid_async: req=%b rd=%h expected 0 00000000", dmem_bus.dmem_req, read_data_m);
        end
        nop();
        #1;
        checks++;
        if (stall_m !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_idle: stall=%b expected 0", stall_m);
        end
        next_cycle();
        rst = 1'b0;
        dmem_bus.dmem_ready = 1'b1;
        dmem_bus.dmem_rdata = 32'h1111_1111;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({dmem_bus.dmem_req, stall_m, read_data_m} !== {2'b00, 32'h0}) begin
                failures++;
                $display("FAIL rstmid_late_ready[%0d]: req=%b stall=%b rd=%h expected 0 0 00000000", c,
                         dmem_bus.dmem_req, stall_m, read_data_m);
            end
            next_cycle();
        end
        dmem_bus.dmem_ready = 1'b0;
        last_rd = 32'h0;
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_lw_zero_wait();
        test_load_extend();
        test_sh_wait();
        test_store_lanes();
        test_misalign();
        test_back_to_back();
        test_reset_mid_txn();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
